// File: rtl/adc_driver.sv
`default_nettype none
// ============================================================================
//  Module   : adc_driver
//  Purpose  : Parallel-interface master for an 8-channel, 16-bit
//             simultaneous-sampling SAR ADC (ADS8568-style). Periodically
//             pulses CONVST on all four channel pairs, waits out BUSY, then
//             reads the eight results (A0,A1,B0,B1,C0,C1,D0,D1) over DB and
//             presents each word on data_out with a one-cycle data_valid.
//  Ports    : clk            system clock (also the ADC XCLK)
//             sresetn        asynchronous reset, active HIGH (legacy name)
//             busy           ADC BUSY, asynchronous, synchronized here
//             data_adc[15:0] ADC DB bus
//             read_n         ADC RD_N
//             write_n        ADC WR_N, tied inactive
//             chipselect_n   ADC CS_N
//             software_mode  ADC HW_N/SW, tied to hardware mode
//             serial_mode    tied to parallel mode
//             standby_n      tied to active
//             conv_start_a..d CONVST_A..D, driven identically
//             data_out[15:0] last word read, held until the next word
//             data_valid     one-cycle strobe, coincident with data_out update
//  Revision : 1.0  initial release
// ============================================================================
module adc_driver #(
   parameter int CONV_PERIOD    = 75,
   parameter int CONVST_CYCLES  = 2,
   parameter int NUM_CH         = 8,
   parameter int RD_LOW_CYCLES  = 2,
   parameter int RD_HIGH_CYCLES = 1,
   parameter int BUSY_TIMEOUT   = 32
) (
   input  logic        clk,
   input  logic        sresetn,
   input  logic        busy,
   input  logic [15:0] data_adc,
   output logic        read_n,
   output logic        write_n,
   output logic        chipselect_n,
   output logic        software_mode,
   output logic        serial_mode,
   output logic        standby_n,
   output logic        conv_start_a,
   output logic        conv_start_b,
   output logic        conv_start_c,
   output logic        conv_start_d,
   output logic [15:0] data_out,
   output logic        data_valid
);

   localparam int C_PER_W   = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
   localparam int C_MAX_A   = (CONVST_CYCLES > BUSY_TIMEOUT) ? CONVST_CYCLES : BUSY_TIMEOUT;
   localparam int C_MAX_B   = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
   localparam int C_MAX_CYC = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
   localparam int C_CYC_W   = $clog2(C_MAX_CYC + 1);
   localparam int C_WORD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [C_PER_W-1:0]  C_PERIOD_LAST  = C_PER_W'(CONV_PERIOD - 1);
   localparam logic [C_CYC_W-1:0]  C_CONVST_LAST  = C_CYC_W'(CONVST_CYCLES - 1);
   localparam logic [C_CYC_W-1:0]  C_TIMEOUT_LAST = C_CYC_W'(BUSY_TIMEOUT - 1);
   localparam logic [C_CYC_W-1:0]  C_RDL_LAST     = C_CYC_W'(RD_LOW_CYCLES - 1);
   localparam logic [C_CYC_W-1:0]  C_RDH_LAST     = C_CYC_W'(RD_HIGH_CYCLES - 1);
   localparam logic [C_WORD_W-1:0] C_WORD_LAST    = C_WORD_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CONVST      = 3'd1,
      ST_WAIT_BUSY_H = 3'd2,
      ST_WAIT_BUSY_L = 3'd3,
      ST_RD_LOW      = 3'd4,
      ST_RD_HIGH     = 3'd5
   } state_t;

   state_t              state_q,      state_d;
   logic [C_PER_W-1:0]  period_cnt_q, period_cnt_d;
   logic                pending_q,    pending_d;
   logic [C_CYC_W-1:0]  cyc_cnt_q,    cyc_cnt_d;
   logic [C_WORD_W-1:0] word_q,       word_d;
   logic                busy_meta_q,  busy_meta_d;
   logic                busy_sync_q,  busy_sync_d;
   logic                read_n_q,     read_n_d;
   logic                cs_n_q,       cs_n_d;
   logic                conv_q,       conv_d;
   logic [15:0]         data_out_q,   data_out_d;
   logic                data_valid_q, data_valid_d;

   logic                w_period_hit;

   assign w_period_hit = (period_cnt_q == C_PERIOD_LAST);

   always_comb begin
      state_d      = state_q;
      cyc_cnt_d    = cyc_cnt_q;
      word_d       = word_q;
      read_n_d     = read_n_q;
      cs_n_d       = cs_n_q;
      conv_d       = conv_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      busy_meta_d  = busy;
      busy_sync_d  = busy_meta_q;
      period_cnt_d = w_period_hit ? '0 : period_cnt_q + 1'b1;
      // A period that elapses mid-transaction is remembered so the next
      // conversion launches as soon as the FSM is idle again.
      pending_d    = pending_q | (w_period_hit && (state_q != ST_IDLE));

      unique case (state_q)
         ST_IDLE: begin
            if (w_period_hit || pending_q) begin
               state_d      = ST_CONVST;
               conv_d       = 1'b1;
               cyc_cnt_d    = '0;
               period_cnt_d = '0;
               pending_d    = 1'b0;
            end
         end
         ST_CONVST: begin
            if (cyc_cnt_q == C_CONVST_LAST) begin
               state_d   = ST_WAIT_BUSY_H;
               conv_d    = 1'b0;
               cyc_cnt_d = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         ST_WAIT_BUSY_H: begin
            if (busy_sync_q) begin
               state_d   = ST_WAIT_BUSY_L;
               cyc_cnt_d = '0;
            end else if (cyc_cnt_q == C_TIMEOUT_LAST) begin
               // ADC never acknowledged: abandon this conversion quietly.
               state_d   = ST_IDLE;
               cyc_cnt_d = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         ST_WAIT_BUSY_L: begin
            if (!busy_sync_q) begin
               state_d   = ST_RD_LOW;
               cs_n_d    = 1'b0;
               read_n_d  = 1'b0;
               cyc_cnt_d = '0;
               word_d    = '0;
            end
         end
         ST_RD_LOW: begin
            if (cyc_cnt_q == C_RDL_LAST) begin
               // DB has settled by the end of the low phase.
               state_d      = ST_RD_HIGH;
               data_out_d   = data_adc;
               data_valid_d = 1'b1;
               read_n_d     = 1'b1;
               cyc_cnt_d    = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         ST_RD_HIGH: begin
            if (cyc_cnt_q == C_RDH_LAST) begin
               cyc_cnt_d = '0;
               if (word_q != C_WORD_LAST) begin
                  state_d  = ST_RD_LOW;
                  word_d   = word_q + 1'b1;
                  read_n_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  cs_n_d  = 1'b1;
               end
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            conv_d   = 1'b0;
            read_n_d = 1'b1;
            cs_n_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge sresetn) begin
      if (sresetn) begin
         state_q      <= ST_IDLE;
         period_cnt_q <= '0;
         pending_q    <= 1'b0;
         cyc_cnt_q    <= '0;
         word_q       <= '0;
         busy_meta_q  <= 1'b0;
         busy_sync_q  <= 1'b0;
         read_n_q     <= 1'b1;
         cs_n_q       <= 1'b1;
         conv_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         pending_q    <= pending_d;
         cyc_cnt_q    <= cyc_cnt_d;
         word_q       <= word_d;
         busy_meta_q  <= busy_meta_d;
         busy_sync_q  <= busy_sync_d;
         read_n_q     <= read_n_d;
         cs_n_q       <= cs_n_d;
         conv_q       <= conv_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign read_n        = read_n_q;
   assign chipselect_n  = cs_n_q;
   assign conv_start_a  = conv_q;
   assign conv_start_b  = conv_q;
   assign conv_start_c  = conv_q;
   assign conv_start_d  = conv_q;
   assign data_out      = data_out_q;
   assign data_valid    = data_valid_q;
   assign write_n       = 1'b1;
   assign software_mode = 1'b0;
   assign serial_mode   = 1'b0;
   assign standby_n     = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_adc_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_driver
//  Purpose  : Self-checking bench for adc_driver. An ADC model answers each
//             conversion with BUSY and a table of sine samples; expected
//             words are queued when BUSY is raised and a monitor pops and
//             compares them on every data_valid. A protocol monitor tracks
//             CONVST spacing, RD_N pulse widths and chip-select framing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_driver;

   localparam int M_NORMAL  = 0;
   localparam int M_NOBUSY  = 1;
   localparam int M_STRETCH = 2;

   logic        clk;
   logic        sresetn;
   logic        busy;
   logic [15:0] data_adc;
   logic        read_n, write_n, chipselect_n;
   logic        software_mode, serial_mode, standby_n;
   logic        conv_start_a, conv_start_b, conv_start_c, conv_start_d;
   logic [15:0] data_out;
   logic        data_valid;

   int checks   = 0;
   int failures = 0;

   int adc_mode = M_NORMAL;
   int conv_cnt = 0;
   int cur_conv = 0;
   logic [15:0] exp_q [$];
   // One sine cycle in 8 steps, full scale 16384 (two's complement).
   logic [15:0] sine_tab [8] = '{16'h0000, 16'h2D41, 16'h4000, 16'h2D41,
                                 16'h0000, 16'hD2BF, 16'hC000, 16'hD2BF};

   int   cyc = 0, n_rises = 0, n_bursts = 0, last_rise = 0, cs_rise = 0;
   int   last_interval = 0;
   bit   have_last_rise = 1'b0, check_period = 1'b1;
   int   conv_hi = 0, rd_lo = 0, rd_cnt = 0, dv_cnt = 0;
   int   total_rd = 0, total_dv = 0;
   int   conv_mismatch = 0, overlap_err = 0, const_err = 0, rd_outside_err = 0;
   logic prev_conv = 1'b0, prev_rd = 1'b1, prev_cs = 1'b1;

   adc_driver dut (
      .clk           (clk),
      .sresetn       (sresetn),
      .busy          (busy),
      .data_adc      (data_adc),
      .read_n        (read_n),
      .write_n       (write_n),
      .chipselect_n  (chipselect_n),
      .software_mode (software_mode),
      .serial_mode   (serial_mode),
      .standby_n     (standby_n),
      .conv_start_a  (conv_start_a),
      .conv_start_b  (conv_start_b),
      .conv_start_c  (conv_start_c),
      .conv_start_d  (conv_start_d),
      .data_out      (data_out),
      .data_valid    (data_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input int conv, input int ch);
      return sine_tab[(conv + ch) % 8] + 16'(ch);
   endfunction

   // ADC BUSY model: queues the expected burst when it raises BUSY.
   initial begin
      int mode_now;
      busy = 1'b0;
      forever begin
         @(posedge conv_start_a);
         mode_now = adc_mode;
         if (mode_now == M_NOBUSY) begin
            // Late BUSY, after the driver has given up: must be ignored.
            repeat (50) @(negedge clk);
            busy = 1'b1;
            repeat (4) @(negedge clk);
            busy = 1'b0;
         end else begin
            repeat (3) @(negedge clk);
            busy     = 1'b1;
            cur_conv = conv_cnt;
            conv_cnt++;
            for (int ch = 0; ch < 8; ch++) exp_q.push_back(word_of(cur_conv, ch));
            repeat ((mode_now == M_STRETCH) ? 120 : 10) @(negedge clk);
            busy = 1'b0;
         end
      end
   end

   // ADC DB model: garbage during the first low cycle of RD_N, valid after.
   initial begin
      int rd_word;
      int lo;
      rd_word  = 0;
      lo       = 0;
      data_adc = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (sresetn || chipselect_n) begin
            rd_word  = 0;
            lo       = 0;
            data_adc = 16'hDEAD;
         end else if (!read_n) begin
            lo++;
            data_adc = (lo >= 2) ? word_of(cur_conv, rd_word) : 16'hDEAD;
         end else begin
            if (lo > 0) rd_word++;
            lo = 0;
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [15:0] exp_w;
      if (!sresetn && data_valid === 1'b1) begin
         check("sb_has_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("data_word", data_out, exp_w);
         end
      end
   end

   // Protocol monitor.
   always @(negedge clk) begin
      if (sresetn) begin
         prev_conv      = 1'b0;
         prev_rd        = 1'b1;
         prev_cs        = 1'b1;
         conv_hi        = 0;
         rd_lo          = 0;
         rd_cnt         = 0;
         dv_cnt         = 0;
         have_last_rise = 1'b0;
      end else begin
         cyc++;
         if (conv_start_b !== conv_start_a || conv_start_c !== conv_start_a ||
             conv_start_d !== conv_start_a) conv_mismatch++;
         if (!chipselect_n && conv_start_a) overlap_err++;
         if (write_n !== 1'b1 || software_mode !== 1'b0 || serial_mode !== 1'b0 ||
             standby_n !== 1'b1) const_err++;
         if (!read_n && chipselect_n) rd_outside_err++;

         if (conv_start_a && !prev_conv) begin
            if (have_last_rise) begin
               last_interval = cyc - last_rise;
               if (check_period) check("conv_period", last_interval, 75);
            end
            last_rise      = cyc;
            have_last_rise = 1'b1;
            n_rises++;
         end
         if (conv_start_a) conv_hi++;
         else if (prev_conv) begin
            check("convst_width", conv_hi, 2);
            conv_hi = 0;
         end

         if (!read_n) rd_lo++;
         else if (!prev_rd) begin
            check("rd_low_width", rd_lo, 2);
            rd_lo = 0;
            rd_cnt++;
            total_rd++;
         end
         if (data_valid) begin
            dv_cnt++;
            total_dv++;
         end
         if (chipselect_n && !prev_cs) begin
            check("burst_reads", rd_cnt, 8);
            check("burst_valids", dv_cnt, 8);
            cs_rise = cyc;
            rd_cnt  = 0;
            dv_cnt  = 0;
            n_bursts++;
         end
         prev_conv = conv_start_a;
         prev_rd   = read_n;
         prev_cs   = chipselect_n;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_read_n"},        read_n,        1);
      check({tag, "_chipselect_n"},  chipselect_n,  1);
      check({tag, "_write_n"},       write_n,       1);
      check({tag, "_conv_a"},        conv_start_a,  0);
      check({tag, "_conv_b"},        conv_start_b,  0);
      check({tag, "_conv_c"},        conv_start_c,  0);
      check({tag, "_conv_d"},        conv_start_d,  0);
      check({tag, "_data_out"},      data_out,      0);
      check({tag, "_data_valid"},    data_valid,    0);
      check({tag, "_software_mode"}, software_mode, 0);
      check({tag, "_serial_mode"},   serial_mode,   0);
      check({tag, "_standby_n"},     standby_n,     1);
   endtask

   // Call right after releasing reset on a negative edge.
   task automatic measure_first_rise();
      int n;
      n = 0;
      for (int i = 1; i <= 200 && n == 0; i++) begin
         @(posedge clk);
         #1;
         if (conv_start_a === 1'b1) n = i;
      end
      check("first_conv_delay", n, 75);
      check("first_conv_b", conv_start_b, 1);
      check("first_conv_c", conv_start_c, 1);
      check("first_conv_d", conv_start_d, 1);
   endtask

   task automatic wait_rises(input int target, input int budget);
      for (int i = 0; i < budget && n_rises < target; i++) @(posedge clk);
      check("rises_reached", n_rises, target);
   endtask

   initial begin
      int rd0, dv0, nb, gap;
      bit found;
      sresetn = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");

      // Power-up and nominal operation over 100 conversions.
      sresetn = 1'b0;
      measure_first_rise();
      wait_rises(n_rises + 99, 99 * 75 + 300);

      // BUSY never answers: timeout, no reads, retried on schedule.
      adc_mode = M_NOBUSY;
      wait_rises(n_rises + 1, 200);
      adc_mode = M_NORMAL;
      rd0 = total_rd;
      dv0 = total_dv;
      wait_rises(n_rises + 1, 200);
      check("timeout_no_reads", total_rd - rd0, 0);
      check("timeout_no_valids", total_dv - dv0, 0);

      // BUSY stretched past the period: next CONVST deferred to burst end.
      adc_mode = M_STRETCH;
      wait_rises(n_rises + 1, 200);
      check_period = 1'b0;
      adc_mode     = M_NORMAL;
      wait_rises(n_rises + 1, 400);
      gap = last_rise - cs_rise;
      check("defer_after_burst", (gap >= 1 && gap <= 2), 1);
      check("defer_interval_long", (last_interval > 75), 1);
      check_period = 1'b1;
      wait_rises(n_rises + 1, 200);

      // Reset during the 4th word read.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk);
         #1;
         if (rd_cnt == 3 && read_n === 1'b0 && chipselect_n === 1'b0) found = 1'b1;
      end
      check("found_4th_read", found, 1);
      #2;
      sresetn = 1'b1;
      #1;
      check("midrst_read_n", read_n, 1);
      check("midrst_chipselect_n", chipselect_n, 1);
      check("midrst_data_valid", data_valid, 0);
      check("midrst_data_out", data_out, 0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst_hold");
      sresetn = 1'b0;
      measure_first_rise();
      nb = n_bursts;
      for (int i = 0; i < 200 && n_bursts == nb; i++) @(posedge clk);
      check("restart_burst_done", n_bursts, nb + 1);
      check("sb_empty", exp_q.size(), 0);

      check("conv_pins_identical", conv_mismatch, 0);
      check("conv_vs_cs_overlap", overlap_err, 0);
      check("constant_outputs", const_err, 0);
      check("read_outside_cs", rd_outside_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
